// File: rtl/booth_controller_if.sv
// Signal bundle between the radix-2 Booth controller and its environment:
// upstream handshake, datapath status flags and datapath control strobes.
interface booth_controller_if;
  // Upstream handshake
  logic start;
  logic abort;
  logic ready;
  logic operand_sel;
  logic busy;
  logic valid;

  // Datapath status
  logic q0;
  logic q1;
  logic done;

  // Datapath controls
  logic clr_A;
  logic enA;
  logic clr_Q;
  logic enQ;
  logic shift;
  logic enM;
  logic clrff;
  logic clr_count;
  logic dec;
  logic clr_r;
  logic sub_add;

  // Controller side
  modport master (
    input  start,
    input  abort,
    input  q0,
    input  q1,
    input  done,
    output ready,
    output operand_sel,
    output busy,
    output valid,
    output clr_A,
    output enA,
    output clr_Q,
    output enQ,
    output shift,
    output enM,
    output clrff,
    output clr_count,
    output dec,
    output clr_r,
    output sub_add
  );

  // Datapath / upstream side
  modport slave (
    output start,
    output abort,
    output q0,
    output q1,
    output done,
    input  ready,
    input  operand_sel,
    input  busy,
    input  valid,
    input  clr_A,
    input  enA,
    input  clr_Q,
    input  enQ,
    input  shift,
    input  enM,
    input  clrff,
    input  clr_count,
    input  dec,
    input  clr_r,
    input  sub_add
  );
endinterface

// File: rtl/booth_controller.sv
// Moore control FSM sequencing a 5-bit radix-2 Booth multiplier datapath.
// Optional BOOTH_INT_COUNT_EN: internal iteration counter replaces the done input.
module booth_controller #(
  parameter int N     = 5,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               clr_n,
  booth_controller_if.master bus
`ifdef BOOTH_INT_COUNT_EN
  ,
  output logic [CNT_W-1:0]   dbg_iter
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_CHECK  = 3'd3,
    S_ADD    = 3'd4,
    S_SUB    = 3'd5,
    S_SHIFT  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   iter_done;
  logic   abort_active;

  // abort only has an effect once a multiply is under way
  assign abort_active = bus.abort && (state_reg != S_IDLE);

`ifdef BOOTH_INT_COUNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == S_LOAD_Q) begin
      cnt_next = CNT_W'(N);
    end else if (state_reg == S_SHIFT && cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  assign iter_done = (cnt_reg == '0);
  assign dbg_iter  = cnt_reg;
`else
  assign iter_done = bus.done;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = S_LOAD_M;
        end
      end
      S_LOAD_M: state_next = S_LOAD_Q;
      S_LOAD_Q: state_next = S_CHECK;
      S_CHECK: begin
        // Termination wins over the bit-pair decode
        if (iter_done) begin
          state_next = S_DONE;
        end else begin
          case ({bus.q0, bus.q1})
            2'b01:   state_next = S_ADD;
            2'b10:   state_next = S_SUB;
            default: state_next = S_SHIFT;
          endcase
        end
      end
      S_ADD:   state_next = S_SHIFT;
      S_SUB:   state_next = S_SHIFT;
      S_SHIFT: state_next = S_CHECK;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_active) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    bus.ready       = 1'b0;
    bus.operand_sel = 1'b0;
    bus.busy        = 1'b0;
    bus.valid       = 1'b0;
    bus.clr_A       = 1'b0;
    bus.enA         = 1'b0;
    bus.clr_Q       = 1'b0;
    bus.enQ         = 1'b0;
    bus.shift       = 1'b0;
    bus.enM         = 1'b0;
    bus.clrff       = 1'b0;
    bus.clr_count   = 1'b0;
    bus.dec         = 1'b0;
    bus.clr_r       = 1'b0;
    bus.sub_add     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        bus.ready = 1'b1;
      end
      S_LOAD_M: begin
        bus.enM  = 1'b1;
        bus.busy = 1'b1;
      end
      S_LOAD_Q: begin
        bus.enQ         = 1'b1;
        bus.clr_A       = 1'b1;
        bus.clrff       = 1'b1;
        bus.clr_count   = 1'b1;
        bus.clr_r       = 1'b1;
        bus.operand_sel = 1'b1;
        bus.busy        = 1'b1;
      end
      S_CHECK: begin
        bus.busy = 1'b1;
      end
      S_ADD: begin
        bus.enA  = 1'b1;
        bus.busy = 1'b1;
      end
      S_SUB: begin
        bus.enA     = 1'b1;
        bus.sub_add = 1'b1;
        bus.busy    = 1'b1;
      end
      S_SHIFT: begin
        bus.shift = 1'b1;
        bus.dec   = 1'b1;
        bus.busy  = 1'b1;
      end
      S_DONE: begin
        bus.valid = 1'b1;
        bus.busy  = 1'b1;
      end
      default: begin
        bus.ready = 1'b0;
      end
    endcase
    // Cancel path: flush the datapath and swallow any pending result pulse
    if (abort_active) begin
      bus.clr_A = 1'b1;
      bus.clr_Q = 1'b1;
      bus.clr_r = 1'b1;
      bus.valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller driving a small behavioural Booth datapath
// (A, Q, M, Q(-1), iteration counter) and checking controls, latency and products.
`timescale 1ns/1ps
module tb_booth_controller;
  localparam int N     = 5;
  localparam int CNT_W = 3;

  // {ready,operand_sel,busy,valid,clr_A,enA,clr_Q,enQ,shift,enM,clrff,clr_count,dec,clr_r,sub_add}
  localparam logic [14:0] V_IDLE   = 15'h4000;
  localparam logic [14:0] V_LOAD_M = 15'h1020;
  localparam logic [14:0] V_LOAD_Q = 15'h349A;
  localparam logic [14:0] V_CHECK  = 15'h1000;
  localparam logic [14:0] V_ADD    = 15'h1200;
  localparam logic [14:0] V_SHIFT  = 15'h1044;
  localparam logic [14:0] V_DONE   = 15'h1800;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  booth_controller_if bus();

`ifdef BOOTH_INT_COUNT_EN
  logic [CNT_W-1:0] dbg_iter;
  booth_controller #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .bus      (bus),
    .dbg_iter (dbg_iter)
  );
`else
  booth_controller #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );
`endif

  always #5 clk = ~clk;

  // Behavioural datapath
  logic [4:0] mcand  = 5'd0;
  logic [4:0] mplier = 5'd0;
  logic [4:0] m_a    = 5'd0;
  logic [4:0] m_q    = 5'd0;
  logic [4:0] m_m    = 5'd0;
  logic       m_ff   = 1'b0;
  logic [2:0] m_cnt  = 3'd0;
  logic [4:0] data_in;
  logic [9:0] data_out;

  assign data_in  = bus.operand_sel ? mplier : mcand;
  assign data_out = {m_a, m_q};
  assign bus.q0   = m_q[0];
  assign bus.q1   = m_ff;
`ifdef BOOTH_INT_COUNT_EN
  assign bus.done = 1'b0;
`else
  assign bus.done = (m_cnt == 3'd0);
`endif

  always @(posedge clk) begin
    if (bus.enM) m_m <= data_in;
    if (bus.clr_A)      m_a <= 5'd0;
    else if (bus.enA)   m_a <= bus.sub_add ? (m_a - m_m) : (m_a + m_m);
    else if (bus.shift) m_a <= {m_a[4], m_a[4:1]};
    if (bus.clr_Q)      m_q <= 5'd0;
    else if (bus.enQ)   m_q <= data_in;
    else if (bus.shift) m_q <= {m_a[0], m_q[4:1]};
    if (bus.clrff)      m_ff <= 1'b0;
    else if (bus.shift) m_ff <= m_q[0];
    if (bus.clr_count)  m_cnt <= 3'(N);
    else if (bus.dec)   m_cnt <= m_cnt - 3'd1;
  end

  function automatic logic [14:0] ctrl_vec();
    return {bus.ready, bus.operand_sel, bus.busy, bus.valid, bus.clr_A, bus.enA,
            bus.clr_Q, bus.enQ, bus.shift, bus.enM, bus.clrff, bus.clr_count,
            bus.dec, bus.clr_r, bus.sub_add};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiply; optionally keeps start high and checks the immediate restart.
  task automatic run_mult(input string tag, input logic [4:0] mc, input logic [4:0] mp,
                          input logic [9:0] exp_prod, input int exp_lat,
                          input int exp_nas, input logic [7:0] exp_seq, input bit hold);
    int cyc = 0;
    int ndec = 0;
    int nas = 0;
    int viol = 0;
    int exp_iter = N;
    bit seen = 0;
    logic [7:0]  seq = 8'd0;
    logic [14:0] v;
    mcand     = mc;
    mplier    = mp;
    bus.start = 1'b1;
    while (!seen && cyc < 40) begin
      tick();
      if (!hold) bus.start = 1'b0;
      cyc++;
      v = ctrl_vec();
      if (cyc == 1) check({tag, "_load_m"}, 32'(v), 32'(V_LOAD_M));
      if (cyc == 2) check({tag, "_load_q"}, 32'(v), 32'(V_LOAD_Q));
      if (cyc == 3) check({tag, "_check"}, 32'(v), 32'(V_CHECK));
      if (bus.shift && (bus.enA || bus.enQ || bus.enM)) viol++;
      if (bus.dec) ndec++;
      if (bus.enA) begin
        nas++;
        seq = {seq[6:0], bus.sub_add};
      end
`ifdef BOOTH_INT_COUNT_EN
      if (v == V_CHECK && exp_iter >= 0) begin
        check({tag, "_dbg_iter"}, 32'(dbg_iter), 32'(exp_iter));
        exp_iter--;
      end
`endif
      if (bus.valid) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_done_vec"}, 32'(ctrl_vec()), 32'(V_DONE));
    check({tag, "_product"}, 32'(data_out), 32'(exp_prod));
    check({tag, "_dec_count"}, 32'(ndec), 32'(N));
    check({tag, "_addsub_count"}, 32'(nas), 32'(exp_nas));
    check({tag, "_sub_add_seq"}, 32'(seq), 32'(exp_seq));
    check({tag, "_shift_excl"}, 32'(viol), 32'd0);
    $display("txn %s: mcand=%h mplier=%h product=%h latency=%0d", tag, mc, mp, data_out, cyc);
    tick();
    check({tag, "_idle"}, 32'(ctrl_vec()), 32'(V_IDLE));
    if (hold) begin
      tick();
      check({tag, "_restart"}, 32'(ctrl_vec()), 32'(V_LOAD_M));
      bus.start = 1'b0;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check({tag, "_restart_abort"}, 32'(ctrl_vec()), 32'(V_IDLE));
    end
  endtask

  // Abort a shift-only multiply after 'at' cycles spent in state exp_vec.
  task automatic abort_at(input string tag, input int at, input logic [14:0] exp_vec);
    mcand     = 5'd7;
    mplier    = 5'd0;
    bus.start = 1'b1;
    for (int i = 0; i < at; i++) begin
      tick();
      bus.start = 1'b0;
    end
    check({tag, "_state"}, 32'(ctrl_vec()), 32'(exp_vec));
    bus.abort = 1'b1;
    #1;
    check({tag, "_clr_valid"}, 32'({bus.clr_A, bus.clr_Q, bus.clr_r, bus.valid}), 32'(4'b1110));
    tick();
    bus.abort = 1'b0;
    check({tag, "_idle"}, 32'(ctrl_vec()), 32'(V_IDLE));
    repeat (3) tick();
    check({tag, "_stay_idle"}, 32'(ctrl_vec()), 32'(V_IDLE));
    $display("txn %s: aborted after %0d cycles", tag, at);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    check("reset_vec", 32'(ctrl_vec()), 32'(V_IDLE));
`ifdef BOOTH_INT_COUNT_EN
    check("reset_dbg_iter", 32'(dbg_iter), 32'd0);
`endif
    #24 clr_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(ctrl_vec()), 32'(V_IDLE));

    run_mult("shift_only", 5'd7, 5'b00000, 10'h000, 14, 0, 8'h00, 1'b0);
    run_mult("3x-2", 5'b00011, 5'b11110, 10'h3FA, 15, 1, 8'h01, 1'b0);
    run_mult("alt_01010", 5'b00011, 5'b01010, 10'h01E, 18, 4, 8'h0A, 1'b0);
    run_mult("-5x7", 5'b11011, 5'b00111, 10'h3DD, 16, 2, 8'h02, 1'b0);

    abort_at("abort_shift2", 6, V_SHIFT);
    run_mult("after_abort", 5'd7, 5'b00000, 10'h000, 14, 0, 8'h00, 1'b0);
    abort_at("abort_done", 14, V_DONE);

    // start together with abort in IDLE must not launch a multiply
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle", 32'(ctrl_vec()), 32'(V_IDLE));

    run_mult("start_held", 5'd7, 5'b00000, 10'h000, 14, 0, 8'h00, 1'b1);

    // Asynchronous reset in the ADD state of multiplier 00010
    mcand     = 5'b00011;
    mplier    = 5'b00010;
    bus.start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.start = 1'b0;
    end
    check("pre_reset_add", 32'(ctrl_vec()), 32'(V_ADD));
    #2 clr_n = 1'b0;
    #1;
    check("async_reset_vec", 32'(ctrl_vec()), 32'(V_IDLE));
    #2 clr_n = 1'b1;
    tick();
    check("async_reset_idle", 32'(ctrl_vec()), 32'(V_IDLE));
    $display("txn async_reset: reset applied in ADD");
    run_mult("after_reset", 5'b00011, 5'b11110, 10'h3FA, 15, 1, 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
